morse_symbol_assembler: RTL and testbench

//  Next-generation Morse front end. Times key presses and gaps against a parametrised

---
 rtl/morse_symbol_assembler.sv | 162 ++++++++++++++++
 tb/tb_morse_symbol_assembler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/morse_symbol_assembler.sv
// Morse front end: times key presses and gaps in units, classifies dot/dash,
// assembles a letter's symbols and hands {code,len} or a word-space marker to
// the downstream lookup through a 1-deep valid/ready output buffer.
module morse_symbol_assembler #(
  parameter int UNIT_CYCLES = 20_000_000,
  parameter int DASH_UNITS  = 3,
  parameter int LG_UNITS    = 3,
  parameter int WG_UNITS    = 7,
  parameter int MAX_SYM     = 6,
  localparam int LW         = $clog2(MAX_SYM + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAX_SYM-1:0] out_code,
  output logic [LW-1:0]      out_len,
  output logic               out_space,
  output logic               overflow,
  output logic               overrun
);
  localparam int PW = $clog2(UNIT_CYCLES);
  localparam int UW = $clog2(WG_UNITS + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  state_t             state_q, state_d;
  logic               b_q;
  logic [PW-1:0]      presc_q, presc_d;
  logic [UW-1:0]      unit_q, unit_d, units_el;
  logic [MAX_SYM-1:0] code_q, code_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ov_q, ov_d;
  logic               vld_q, vld_d;
  logic [MAX_SYM-1:0] ocode_q, ocode_d;
  logic [LW-1:0]      olen_q, olen_d;
  logic               ospace_q, ospace_d;
  logic               overrun_q, overrun_d;

  logic rise, fall, edge_b, tick;
  logic emit, emit_space;
  logic [MAX_SYM-1:0] emit_code;
  logic [LW-1:0]      emit_len;

  // Unit timing. units_el is the elapsed unit count including this cycle's
  // tick, so a press/gap of exactly N units is seen as N at the closing edge.
  always_comb begin
    rise     = b & ~b_q;
    fall     = ~b & b_q;
    edge_b   = rise | fall;
    tick     = (presc_q == PW'(UNIT_CYCLES - 1));
    units_el = (tick && unit_q != UW'(WG_UNITS)) ? unit_q + UW'(1) : unit_q;
    presc_d  = (edge_b || tick) ? '0 : presc_q + PW'(1);
    unit_d   = edge_b ? '0 : units_el;
  end

  // Symbol FSM: accumulate symbols, emit letter on letter gap, space on word gap.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    len_d      = len_q;
    ov_d       = ov_q;
    emit       = 1'b0;
    emit_space = 1'b0;
    emit_code  = '0;
    emit_len   = '0;
    case (state_q)
      IDLE: if (rise) state_d = MARK;
      MARK: if (fall) begin
        if (len_q == LW'(MAX_SYM)) begin
          ov_d = 1'b1;
        end else begin
          code_d = code_q | (MAX_SYM'(units_el >= UW'(DASH_UNITS)) << len_q);
          len_d  = len_q + LW'(1);
        end
        state_d = SPACE;
      end
      SPACE: begin
        if (units_el >= UW'(LG_UNITS)) begin
          // A rise landing on the threshold starts a fresh letter.
          emit      = 1'b1;
          emit_code = code_q;
          emit_len  = len_q;
          code_d    = '0;
          len_d     = '0;
          state_d   = rise ? MARK : GAP;
        end else if (rise) begin
          state_d = MARK;
        end
      end
      GAP: begin
        if (units_el >= UW'(WG_UNITS)) begin
          emit       = 1'b1;
          emit_space = 1'b1;
          state_d    = rise ? MARK : IDLE;
        end else if (rise) begin
          state_d = MARK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer: load when empty or draining, otherwise drop and flag overrun.
  always_comb begin
    vld_d     = vld_q & ~out_ready;
    ocode_d   = ocode_q;
    olen_d    = olen_q;
    ospace_d  = ospace_q;
    overrun_d = 1'b0;
    if (emit) begin
      if (!vld_q || out_ready) begin
        vld_d    = 1'b1;
        ocode_d  = emit_code;
        olen_d   = emit_len;
        ospace_d = emit_space;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers. b_q tracks b during reset so a key held through reset
  // release is not seen as a new press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      b_q       <= b;
      presc_q   <= '0;
      unit_q    <= '0;
      code_q    <= '0;
      len_q     <= '0;
      ov_q      <= 1'b0;
      vld_q     <= 1'b0;
      ocode_q   <= '0;
      olen_q    <= '0;
      ospace_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b;
      presc_q   <= presc_d;
      unit_q    <= unit_d;
      code_q    <= code_d;
      len_q     <= len_d;
      ov_q      <= ov_d;
      vld_q     <= vld_d;
      ocode_q   <= ocode_d;
      olen_q    <= olen_d;
      ospace_q  <= ospace_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = vld_q;
  assign out_code  = ocode_q;
  assign out_len   = olen_q;
  assign out_space = ospace_q;
  assign overflow  = ov_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_morse_symbol_assembler.sv
// Scoreboard bench for morse_symbol_assembler with a 4-cycle unit.
module tb_morse_symbol_assembler;
  localparam int U = 4;
  localparam logic [9:0] SP = 10'h200;

  logic       clk = 1'b0;
  logic       reset, b, out_ready;
  logic       out_valid, out_space, overflow, overrun;
  logic [5:0] out_code;
  logic [2:0] out_len;

  int errs = 0, checks = 0, ovr_cnt = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  morse_symbol_assembler #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .reset(reset), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_len(out_len), .out_space(out_space),
    .overflow(overflow), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] wl(input int code, input int len);
    return {1'b0, 3'(len), 6'(code)};
  endfunction

  // Monitor: count overrun pulses, compare every accepted word to the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("word", 32'({out_space, out_len, out_code}), 32'(sb.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    b = 1'b1;
    tick(n * U);
    b = 1'b0;
  endtask

  task automatic gap(input int n);
    tick(n * U);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 32'({out_valid, out_code, out_len, out_space, overflow, overrun}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; b = 1'b0; out_ready = 1'b1;
    tick(3);
    chk_idle("reset_outputs");
    reset = 1'b0;
    tick(2);

    // 'A': dot, dash, then word space.
    sb.push_back(wl(2, 2)); sb.push_back(SP);
    press(1); gap(1); press(3); gap(10);
    drain("drain_a");

    // Boundaries: 2u press dot, 3u dash, 2u gap in-letter, 3u gap ends letter.
    sb.push_back(wl(2, 2)); sb.push_back(wl(0, 1)); sb.push_back(SP);
    press(2); gap(2); press(3); gap(3); press(1); gap(10);
    drain("drain_bound");
    chk("overflow_clear", 32'(overflow), 32'd0);

    // Seven dots: letter truncated to six, overflow sticky.
    sb.push_back(wl(0, 6)); sb.push_back(SP);
    repeat (7) begin press(1); gap(1); end
    gap(10);
    drain("drain_ovf");
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("ovf_no_overrun", 32'(ovr_cnt), 32'd0);

    // Back-pressure: 'E' held, 'T' dropped with one overrun pulse.
    out_ready = 1'b0;
    sb.push_back(wl(0, 1));
    press(1); gap(4); press(3); gap(4);
    chk("overrun_once", 32'(ovr_cnt), 32'd1);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_word", 32'({out_space, out_len, out_code}), 32'(wl(0, 1)));
    out_ready = 1'b1;
    tick(1);
    chk("valid_drop", 32'(out_valid), 32'd0);
    sb.push_back(SP);
    gap(10);
    drain("drain_bp");

    // Accept and reload in the same cycle.
    out_ready = 1'b0;
    sb.push_back(wl(1, 1)); sb.push_back(SP);
    press(3);
    for (int w = 0; w < 100 && !out_valid; w++) tick(1);
    chk("t5_valid", 32'(out_valid), 32'd1);
    tick(4 * U - 1);
    out_ready = 1'b1;
    tick(1);
    chk("reload_valid", 32'(out_valid), 32'd1);
    chk("reload_space", 32'(out_space), 32'd1);
    chk("reload_no_overrun", 32'(ovr_cnt), 32'd1);
    gap(10);
    drain("drain_reload");

    // Reset mid-dash with key held across reset release.
    b = 1'b1;
    tick(2 * U);
    reset = 1'b1;
    tick(2);
    chk_idle("midreset_outputs");
    reset = 1'b0;
    tick(U);
    b = 1'b0;
    tick(12 * U);
    chk("midreset_no_word", 32'(out_valid), 32'd0);
    sb.push_back(wl(0, 1)); sb.push_back(SP);
    press(1); gap(10);
    drain("drain_after_reset");
    chk("overrun_total", 32'(ovr_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
